// File: rtl/cpp_convert_pkg.sv
// Shared types and constants for the toggle-protocol int/double conversion stages.
package cpp_convert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    localparam int DOUBLE_BIAS = 1023;
    localparam int EXP_W       = 11;
    localparam int MANT_W      = 52;
    localparam int INT_W       = 32;
    // Exponent of a value whose leading one sits at bit INT_W-1.
    localparam int EXP_START   = DOUBLE_BIAS + INT_W - 1;

endpackage

// File: rtl/cpp_update_edge_detect.sv
// Toggle-strobe detector: any level change on the input line yields a one-cycle
// pulse. The previous level keeps tracking the input through reset, so holding
// the line constant across reset release never looks like a request.
module cpp_update_edge_detect (
    input  logic clk,
    input  logic level,
    output logic toggle
);

    logic upd_q;

    // Remember last cycle's level unconditionally.
    always_ff @(posedge clk) begin
        upd_q <= level;
    end

    assign toggle = level ^ upd_q;

endmodule

// File: rtl/cpp_internal_int_to_double_serial.sv
// Serial int32 -> IEEE-754 double converter. Magnitude is normalised one bit per
// clock, so conversion takes 2 + leading-zero-count cycles. Requests arriving
// while busy are parked in a single-entry hold register (latest wins).
module cpp_internal_int_to_double_serial
    import cpp_convert_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in,
    input  logic        update_in,
    output logic [63:0] out,
    output logic        update_out,
    output logic        busy,
    output logic        overrun
);

    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_START);
    localparam int               PAD_W    = MANT_W - (INT_W - 1);

    state_t             state, state_nxt;
    logic               toggle;
    logic               pending;
    logic [INT_W-1:0]   hold;
    logic [INT_W-1:0]   mag;
    logic [EXP_W-1:0]   exp_q;
    logic               sign;
    logic               zero;
    logic               start;
    logic               norm_done;
    logic [INT_W-1:0]   src;
    logic [INT_W-1:0]   src_abs;

    cpp_update_edge_detect u_edge (
        .clk    (clk),
        .level  (update_in),
        .toggle (toggle)
    );

    // A live request beats a parked one when both are present in IDLE.
    assign start     = (state == IDLE) && (toggle || pending);
    assign src       = toggle ? in : hold;
    assign src_abs   = src[INT_W-1] ? (~src + 1'b1) : src;
    assign norm_done = zero || mag[INT_W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (toggle || pending) state_nxt = NORM;
            NORM:    if (norm_done)         state_nxt = PACK;
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: capture, shift-normalise, pack, and busy-request parking.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag        <= '0;
            exp_q      <= '0;
            sign       <= 1'b0;
            zero       <= 1'b0;
            hold       <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            out        <= '0;
            update_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign    <= src[INT_W-1];
                        mag     <= src_abs;
                        zero    <= (src == '0);
                        exp_q   <= EXP_INIT;
                        pending <= 1'b0;
                    end
                end
                NORM: begin
                    if (!norm_done) begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 1'b1;
                    end
                end
                PACK: begin
                    out        <= zero ? 64'h0 : {sign, exp_q, mag[INT_W-2:0], {PAD_W{1'b0}}};
                    update_out <= ~update_out;
                end
                default: ;
            endcase
            if (state != IDLE && toggle) begin
                hold    <= in;
                pending <= 1'b1;
                if (pending) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpp_internal_int_to_double_serial.sv
// Bench for the serial int->double converter: a cycle-level reference model
// (expected value from real arithmetic, latency from leading-zero count) is
// compared against the DUT every cycle, and directed cases pin literal results.
module tb_cpp_internal_int_to_double_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in;
    logic        update_in;
    logic [63:0] out;
    logic        update_out;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    cpp_internal_int_to_double_serial dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .update_in  (update_in),
        .out        (out),
        .update_out (update_out),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Expected double bit pattern of an int32.
    function automatic logic [63:0] to_dbl(input int x);
        if (x == 0) return 64'h0;
        return $realtobits($itor(x));
    endfunction

    // Expected cycles from capture edge to result edge.
    function automatic int lat_of(input int x);
        longint a;
        int top;
        if (x == 0) return 2;
        a = (x < 0) ? -longint'(x) : longint'(x);
        top = 0;
        for (int i = 0; i < 32; i++) if (a[i]) top = i;
        return (31 - top) + 2;
    endfunction

    // ---------------- reference model ----------------
    int          m_cnt;
    logic [63:0] m_res, m_out;
    logic        m_uo, m_ovr, m_pend, m_prev, m_valid;
    logic [31:0] m_hold;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        logic tg;
        if (reset) begin
            m_cnt = 0; m_pend = 0; m_hold = 0; m_ovr = 0;
            m_out = 0; m_uo = 0; m_prev = update_in; m_valid = 1'b1;
        end else if (m_valid) begin
            tg = (update_in != m_prev);
            m_prev = update_in;
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_out = m_res;
                    m_uo  = ~m_uo;
                end
                if (tg) begin
                    if (m_pend) m_ovr = 1'b1;
                    m_hold = in;
                    m_pend = 1'b1;
                end
            end else if (tg) begin
                m_res = to_dbl(int'(in)); m_cnt = lat_of(int'(in)); m_pend = 0;
            end else if (m_pend) begin
                m_res = to_dbl(int'(m_hold)); m_cnt = lat_of(int'(m_hold)); m_pend = 0;
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_out", out, m_out);
            chk("model_update_out", 64'(update_out), 64'(m_uo));
            chk("model_busy", 64'(busy), 64'(m_cnt > 0));
            chk("model_overrun", 64'(overrun), 64'(m_ovr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_one(input logic [31:0] v, input logic [63:0] exp, input int exp_lat, input string name);
        logic prev;
        int   n, bc;
        @(negedge clk);
        in = v; update_in = ~update_in;
        prev = update_out; n = 0; bc = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end while (update_out == prev && n < 60);
        if (n >= 60) begin
            failures++; checks++;
            $display("FAIL %s_timeout no update_out toggle within 60 cycles", name);
        end else begin
            chk({name, "_out"}, out, exp);
            chk({name, "_latency"}, 64'(n - 1), 64'(exp_lat));
            chk({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        end
    endtask

    initial begin
        int toggles, bcount, v;
        logic prev;
        reset = 1'b1; in = 0; update_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out", out, 64'h0);
        chk("reset_flags", {61'b0, update_out, busy, overrun}, 64'h0);

        // Literal pins
        run_one(32'd1,          64'h3FF0000000000000, 33, "one");
        run_one(32'hFFFFFFFF,   64'hBFF0000000000000, 33, "neg_one");
        run_one(32'd0,          64'h0,                 2, "zero");
        run_one(32'h80000000,   64'hC1E0000000000000,  2, "int_min");
        run_one(32'h7FFFFFFF,   64'h41DFFFFFFFC00000,  3, "int_max");
        run_one(32'd3,          64'h4008000000000000, 32, "three");
        chk("no_overrun_yet", 64'(overrun), 64'h0);

        // Coalescing: three requests while converting 1
        @(negedge clk); in = 32'd1; update_in = ~update_in;
        prev = update_out; toggles = 0;
        @(negedge clk); in = 32'd5; update_in = ~update_in;
        @(negedge clk); in = 32'd6; update_in = ~update_in;
        @(negedge clk); in = 32'd7; update_in = ~update_in;
        repeat (80) begin
            @(negedge clk);
            if (update_out != prev) begin
                toggles++;
                prev = update_out;
                if (toggles == 1) chk("coal_first", out, 64'h3FF0000000000000);
            end
        end
        chk("coal_toggles", 64'(toggles), 64'd2);
        chk("coal_last", out, 64'h401C000000000000);
        chk("coal_overrun", 64'(overrun), 64'h1);

        // Reset mid-NORM abandons the job
        @(negedge clk); in = 32'd1; update_in = ~update_in;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_out", out, 64'h0);
        chk("mid_reset_flags", {61'b0, update_out, busy, overrun}, 64'h0);
        bcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || update_out) bcount++;
        end
        chk("quiet_after_reset", 64'(bcount), 64'h0);
        run_one(32'd3, 64'h4008000000000000, 32, "post_reset");

        // Random values through the model plus integer round-trip
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) v = -v;
            run_one(v, to_dbl(v), lat_of(v), "rand");
            chk("rand_roundtrip", 64'($rtoi($bitstoreal(out))), 64'(v));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
